booth_mul_ctrl: RTL and testbench

//  Sequencer for the 8x8 radix-4 Booth multiplier datapath (module datapath).

---
 rtl/booth_mul_ctrl.sv | 155 +++++++++++++++
 tb/tb_booth_mul_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_ctrl.sv
// booth_mul_ctrl: sequencer for the 8x8 radix-4 Booth multiplier datapath.
// It latches both operands on an accepted start and feeds them to the datapath
// over the shared inputnum bus. It then steps the datapath through ITER
// add/shift iterations and captures the product. An iteration count that
// disagrees with the datapath's eqz flag is reported on err.
module booth_mul_ctrl #(
    parameter int WIDTH = 8,
    parameter int ITER  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     mcand,
    input  logic [WIDTH-1:0]     mplier,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [2*WIDTH-1:0]   product,
    output logic [4:0]           dp_ld,
    output logic [4:0]           dp_sel,
    output logic [WIDTH-1:0]     dp_inputnum,
    input  logic                 dp_eqz,
    input  logic [2*WIDTH-1:0]   dp_result
);

    // Iteration counter must be able to hold the value ITER itself.
    localparam int IW = $clog2(ITER + 1);
    localparam logic [IW-1:0] ITER_L = IW'(ITER);

    // Binary state encoding.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_MD = 3'd1;
    localparam logic [2:0] S_LOAD_MP = 3'd2;
    localparam logic [2:0] S_ADD     = 3'd3;
    localparam logic [2:0] S_SHIFT   = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [2:0]         state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [IW-1:0]      iter_q,    iter_d;
    logic               err_q,     err_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    // Next-state logic, operand capture, iteration counting and the eqz watchdog.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        iter_d    = iter_q;
        err_d     = err_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = mcand;
                    mplier_d = mplier;
                    err_d    = 1'b0;
                    iter_d   = '0;
                    state_d  = S_LOAD_MD;
                end
            end
            S_LOAD_MD: state_d = S_LOAD_MP;
            // The extra load cycle lets the datapath's c2md register catch up with md.
            S_LOAD_MP: state_d = S_ADD;
            S_ADD:     state_d = S_SHIFT;
            S_SHIFT: begin
                iter_d  = iter_q + 1'b1;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (dp_eqz) begin
                    // Datapath says finished; it must agree with our own count.
                    state_d = S_DONE;
                    if (iter_q != ITER_L) begin
                        err_d = 1'b1;
                    end
                end else if (iter_q == ITER_L) begin
                    // Datapath never reported zero: stop anyway so we cannot hang.
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = S_ADD;
                end
            end
            S_DONE: begin
                product_d = dp_result;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and capture registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            iter_q    <= '0;
            err_q     <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            iter_q    <= iter_d;
            err_q     <= err_d;
            product_q <= product_d;
        end
    end

    // Moore decode of the datapath control vectors from the current state.
    always_comb begin
        dp_ld       = 5'b00000;
        dp_sel      = 5'b00000;
        dp_inputnum = '0;
        case (state_q)
            S_LOAD_MD: begin
                // md <- mcand, count <- 4, acc <- 0, lastbit <- 0.
                dp_ld       = 5'b10111;
                dp_sel      = 5'b00000;
                dp_inputnum = mcand_q;
            end
            S_LOAD_MP: begin
                // Mpand <- mplier.
                dp_ld       = 5'b01000;
                dp_sel      = 5'b00000;
                dp_inputnum = mplier_q;
            end
            S_ADD: begin
                // acc <- acc + Booth-selected multiple of md.
                dp_ld  = 5'b00100;
                dp_sel = 5'b00100;
            end
            S_SHIFT: begin
                // Arithmetic shift of {acc, Mpand, lastbit} by two; count - 1.
                dp_ld  = 5'b11101;
                dp_sel = 5'b11111;
            end
            default: begin
                dp_ld       = 5'b00000;
                dp_sel      = 5'b00000;
                dp_inputnum = '0;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign err     = err_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// tb_booth_mul_ctrl: drives booth_mul_ctrl against a behavioural radix-4 Booth
// datapath and checks products against plain signed multiplication. Control
// vectors are checked against the per-step table, alongside timing, reset and
// the eqz watchdog.
module tb_booth_mul_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] product;
    logic [4:0]  dp_ld;
    logic [4:0]  dp_sel;
    logic [7:0]  dp_inputnum;
    logic        dp_eqz;
    logic [15:0] dp_result;

    int checks = 0;
    int errors = 0;
    logic [15:0] model_product = 16'h0000;
    logic        force_eqz0 = 1'b0;

    booth_mul_ctrl #(.WIDTH(8), .ITER(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .err(err), .product(product),
        .dp_ld(dp_ld), .dp_sel(dp_sel), .dp_inputnum(dp_inputnum),
        .dp_eqz(dp_eqz), .dp_result(dp_result)
    );

    always #5 clk = ~clk;

    // Behavioural datapath; acc carries two guard bits so the model itself never overflows.
    logic [7:0]        md_r, c2md_r, mpand_r;
    logic signed [9:0] acc_r;
    logic              lastbit_r;
    logic [2:0]        count_r;
    logic signed [9:0] y_val;

    always_comb begin
        y_val = 10'sd0;
        case ({mpand_r[1:0], lastbit_r})
            3'b001, 3'b010: y_val = 10'($signed(md_r));
            3'b011:         y_val = 10'($signed(md_r)) <<< 1;
            3'b100:         y_val = 10'($signed(c2md_r)) <<< 1;
            3'b101, 3'b110: y_val = 10'($signed(c2md_r));
            default:        y_val = 10'sd0;
        endcase
    end

    always @(posedge clk) begin
        c2md_r <= 8'(-md_r);
        if (dp_ld[1]) md_r <= dp_inputnum;
        if (dp_ld[0]) count_r <= dp_sel[0] ? count_r - 3'd1 : 3'd4;
        if (dp_ld[2]) begin
            case (dp_sel[2:1])
                2'b10:   acc_r <= acc_r + y_val;
                2'b11:   acc_r <= acc_r >>> 2;
                default: acc_r <= 10'sd0;
            endcase
        end
        if (dp_ld[3]) mpand_r <= dp_sel[3] ? {acc_r[1:0], mpand_r[7:2]} : dp_inputnum;
        if (dp_ld[4]) lastbit_r <= dp_sel[4] ? mpand_r[1] : 1'b0;
    end

    assign dp_eqz    = force_eqz0 ? 1'b0 : (count_r == 3'd0);
    assign dp_result = {acc_r[7:0], mpand_r};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected {ld, sel, inputnum} k cycles after the accepting edge.
    function automatic logic [17:0] exp_ctrl(input int k, input logic [7:0] a, input logic [7:0] b);
        if (k == 1) return {5'b10111, 5'b00000, a};
        if (k == 2) return {5'b01000, 5'b00000, b};
        if (k >= 3 && k <= 14) begin
            if ((k - 3) % 3 == 0) return {5'b00100, 5'b00100, 8'h00};
            if ((k - 3) % 3 == 1) return {5'b11101, 5'b11111, 8'h00};
        end
        return 18'h0;
    endfunction

    // One full multiply: start for one cycle, operands scrambled after acceptance.
    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic exp_err);
        int prod;
        logic [15:0] exp_p;
        int done_at;
        int done_cnt;
        prod  = $signed(a) * $signed(b);
        exp_p = prod[15:0];
        done_at  = 0;
        done_cnt = 0;
        @(negedge clk);
        mcand = a; mplier = b; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                mcand = 8'($urandom);
                mplier = 8'($urandom);
                check("busy_after_start", 32'(busy), 32'd1);
                check("err_cleared", 32'(err), 32'd0);
            end
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            check("ctrl_vectors", 32'({dp_ld, dp_sel, dp_inputnum}), 32'(exp_ctrl(k, a, b)));
            if (k == 15) check("product_held", 32'(product), 32'(model_product));
        end
        check("done_cycle", 32'(done_at), 32'd15);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("product", 32'(product), 32'(exp_p));
        check("idle_after", 32'(busy), 32'd0);
        check("err_flag", 32'(err), 32'(exp_err));
        model_product = exp_p;
        $display("mul a=%0d b=%0d product=%h expected=%h err=%0d", $signed(a), $signed(b), product, exp_p, err);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cnt;
        int first_at;
        int second_at;
        rst = 1'b1; start = 1'b0; mcand = 8'h00; mplier = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({busy, done, err, dp_ld, dp_sel, dp_inputnum}), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        rst = 1'b0;
        $display("reset checked");

        // Directed products.
        run_mul(8'd3, 8'd5, 1'b0);
        run_mul(8'hFA, 8'd7, 1'b0);
        run_mul(8'd7, 8'hFA, 1'b0);
        run_mul(8'd0, 8'hFF, 1'b0);
        run_mul(8'hFF, 8'hFF, 1'b0);
        run_mul(8'hE0, 8'h80, 1'b0);
        run_mul(8'd31, 8'h7F, 1'b0);

        // Random products within the supported multiplicand range.
        for (int i = 0; i < 20; i++) begin
            int a;
            a = int'($urandom_range(0, 63)) - 32;
            run_mul(8'(a), 8'($urandom), 1'b0);
        end

        // start held high: one multiply per 16 cycles, product stable mid-operation.
        done_cnt = 0; first_at = 0; second_at = 0;
        @(negedge clk);
        mcand = 8'd9; mplier = 8'hF3; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 31) start = 1'b0;
            if (done) begin
                done_cnt++;
                if (first_at == 0) first_at = k;
                else if (second_at == 0) second_at = k;
            end
            if (k == 20) check("held_product_mid", 32'(product), 32'h0000FF8B);
        end
        check("held_done_count", 32'(done_cnt), 32'd2);
        check("held_first_done", 32'(first_at), 32'd15);
        check("held_second_done", 32'(second_at), 32'd31);
        check("held_idle", 32'(busy), 32'd0);
        model_product = 16'hFF8B;
        $display("held-start done_count=%0d at %0d,%0d product=%h", done_cnt, first_at, second_at, product);

        // Reset during ADD of the second iteration.
        @(negedge clk);
        mcand = 8'd5; mplier = 8'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_in_add", 32'(dp_ld), 32'h04);
        rst = 1'b1;
        @(negedge clk);
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_ld", 32'(dp_ld), 32'd0);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("reset_no_done", 32'(done_cnt), 32'd0);
        model_product = 16'h0000;
        $display("reset mid-op done_count=%0d busy=%0d", done_cnt, busy);
        run_mul(8'd5, 8'd6, 1'b0);

        // eqz never asserted: watchdog ends the run with err, next start clears it.
        force_eqz0 = 1'b1;
        run_mul(8'd4, 8'hFD, 1'b1);
        force_eqz0 = 1'b0;
        run_mul(8'hF0, 8'd11, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
